// File: rtl/poly_decompress_pkg.sv
// Shared constants and types for the Kyber polynomial decompressor and the
// ciphertext decoder that reuses its coefficient arithmetic.
package poly_decompress_pkg;

    localparam int KYBER_Q = 3329;
    localparam int KYBER_N = 256;

    // Widest compressed coefficient (d = 11) and the bit-buffer depth
    localparam int MAX_D   = 11;
    localparam int BUF_W   = 24;
    localparam int FILL_W  = 5;
    localparam int D_W     = 5;
    localparam int BCNT_W  = 9;

    localparam logic [1:0] D_SEL_4  = 2'b00;
    localparam logic [1:0] D_SEL_5  = 2'b01;
    localparam logic [1:0] D_SEL_10 = 2'b10;
    localparam logic [1:0] D_SEL_11 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [D_W-1:0] d_of_sel(input logic [1:0] sel);
        logic [D_W-1:0] d;
        case (sel)
            D_SEL_4:  d = 5'd4;
            D_SEL_5:  d = 5'd5;
            D_SEL_10: d = 5'd10;
            default:  d = 5'd11;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/decompress_coeff.sv
// Combinational Kyber decompression of one coefficient:
// (x * q + 2^(d-1)) >> d, evaluated in 32-bit unsigned arithmetic.
module decompress_coeff #(
    parameter int KYBER_Q = poly_decompress_pkg::KYBER_Q
) (
    input  logic [10:0] x,
    input  logic [4:0]  d,
    output logic [15:0] coeff
);
    logic [31:0] prod;
    logic [31:0] rnd;
    logic [31:0] sum;

    always_comb begin
        prod  = 32'(x) * 32'(KYBER_Q);
        rnd   = 32'd1 << (d - 5'd1);
        sum   = prod + rnd;
        coeff = 16'(sum >> d);
    end

endmodule

// File: rtl/poly_decompress.sv
// Unpacks a little-endian LSB-first byte stream of d-bit compressed values
// into KYBER_N decompressed coefficients behind a one-entry output register.
module poly_decompress #(
    parameter int KYBER_Q = poly_decompress_pkg::KYBER_Q,
    parameter int KYBER_N = poly_decompress_pkg::KYBER_N
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  d_sel,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [15:0] out_coeff,
    output logic [7:0]  out_idx,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);
    import poly_decompress_pkg::*;

    state_e              state_q, state_d;
    logic [D_W-1:0]      d_q, d_d;
    logic [BUF_W-1:0]    buf_q, buf_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [BCNT_W-1:0]   ext_cnt_q, ext_cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [15:0]         out_coeff_q, out_coeff_d;
    logic [7:0]          out_idx_q, out_idx_d;

    logic                start_accept;
    logic                in_fire;
    logic                out_fire;
    logic                extract;
    logic [BCNT_W-1:0]   byte_limit;
    logic [10:0]         x_mask;
    logic [10:0]         x_val;
    logic [15:0]         coeff;
    logic [BUF_W-1:0]    shifted;
    logic [FILL_W-1:0]   fill_tmp;

    decompress_coeff #(
        .KYBER_Q (KYBER_Q)
    ) u_coeff (
        .x     (x_val),
        .d     (d_q),
        .coeff (coeff)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (out_fire && (out_idx_q == 8'(KYBER_N - 1))) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        byte_limit = {d_q[3:0], 5'd0};
        in_ready   = (state_q == ST_RUN) && (fill_q < d_q) && (byte_cnt_q < byte_limit);
        busy       = (state_q == ST_RUN);
        done       = (state_q == ST_DONE);
    end

    // Datapath: bit buffer, extraction into the output register, counters
    always_comb begin
        start_accept = (state_q == ST_IDLE) && start;
        in_fire      = in_valid && in_ready;
        out_fire     = out_valid_q && out_ready;
        extract      = (state_q == ST_RUN) && (fill_q >= d_q)
                       && (!out_valid_q || out_ready)
                       && (ext_cnt_q < BCNT_W'(KYBER_N));
        x_mask       = 11'((12'd1 << d_q) - 12'd1);
        x_val        = buf_q[10:0] & x_mask;

        d_d         = d_q;
        buf_d       = buf_q;
        fill_d      = fill_q;
        byte_cnt_d  = byte_cnt_q;
        ext_cnt_d   = ext_cnt_q;
        out_valid_d = out_valid_q;
        out_coeff_d = out_coeff_q;
        out_idx_d   = out_idx_q;
        shifted     = buf_q;
        fill_tmp    = fill_q;

        if (start_accept) begin
            d_d         = d_of_sel(d_sel);
            buf_d       = '0;
            fill_d      = '0;
            byte_cnt_d  = '0;
            ext_cnt_d   = '0;
            out_valid_d = 1'b0;
            out_idx_d   = '0;
        end else begin
            if (out_fire) out_valid_d = 1'b0;
            if (extract) begin
                shifted     = buf_q >> d_q;
                fill_tmp    = fill_q - d_q;
                out_valid_d = 1'b1;
                out_coeff_d = coeff;
                out_idx_d   = ext_cnt_q[7:0];
                ext_cnt_d   = ext_cnt_q + 9'd1;
            end
            buf_d  = shifted;
            fill_d = fill_tmp;
            // New byte lands directly above whatever valid bits remain
            if (in_fire) begin
                buf_d      = shifted | (BUF_W'(in_data) << fill_tmp);
                fill_d     = fill_tmp + 5'd8;
                byte_cnt_d = byte_cnt_q + 9'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q         <= '0;
            buf_q       <= '0;
            fill_q      <= '0;
            byte_cnt_q  <= '0;
            ext_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_coeff_q <= '0;
            out_idx_q   <= '0;
        end else begin
            d_q         <= d_d;
            buf_q       <= buf_d;
            fill_q      <= fill_d;
            byte_cnt_q  <= byte_cnt_d;
            ext_cnt_q   <= ext_cnt_d;
            out_valid_q <= out_valid_d;
            out_coeff_q <= out_coeff_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_coeff = out_coeff_q;
    assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_poly_decompress.sv
// Directed bench for poly_decompress: streams byte patterns, stalls the
// consumer, aborts with reset and checks every coefficient against a reference.
module tb_poly_decompress;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  d_sel = 2'b00;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_coeff;
    logic [7:0]  out_idx;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    int g_nout, g_nbytes, g_ndone;
    logic [15:0] g_first [0:1];

    poly_decompress dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .d_sel     (d_sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_coeff (out_coeff),
        .out_idx   (out_idx),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gen_byte(input int pat, input int i);
        logic [7:0] b;
        case (pat)
            0: b = 8'h00;
            1: b = (i == 0) ? 8'h21 : 8'(i * 73 + 5);
            default: b = (i == 0) ? 8'hFF : (i == 1) ? 8'h03 : 8'(i * 29 + 11);
        endcase
        return b;
    endfunction

    function automatic int dval(input logic [1:0] sel);
        case (sel)
            2'b00: return 4;
            2'b01: return 5;
            2'b10: return 10;
            default: return 11;
        endcase
    endfunction

    // Reference: pull bit-serially from the byte stream, then decompress
    function automatic int ref_coeff(input int pat, input int d, input int k);
        int x = 0;
        for (int b = 0; b < d; b++) begin
            int pos = k * d + b;
            logic [7:0] by = gen_byte(pat, pos / 8);
            if (by[pos % 8]) x = x | (1 << b);
        end
        return (x * 3329 + (1 << (d - 1))) >> d;
    endfunction

    task automatic run_poly(input logic [1:0] sel, input int pat, input bit stall,
                            input int abort_at, input bit poke);
        int d, stall_left, stall_run, cyc;
        bit holding, finished;
        logic [15:0] held_c;
        logic [7:0]  held_i;
        d = dval(sel);
        g_nout = 0; g_nbytes = 0; g_ndone = 0;
        holding = 0; stall_left = 0; stall_run = 0; finished = 0;
        @(negedge clk);
        start = 1'b1; d_sel = sel;
        @(negedge clk);
        start = 1'b0; d_sel = ~sel;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %b expected 1", busy);
        end
        for (cyc = 0; cyc < 20000; cyc++) begin
            if (holding) begin
                checks++;
                if (out_coeff !== held_c || out_idx !== held_i || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL hold_stable: got v=%b idx=%0d coeff=%0d expected v=1 idx=%0d coeff=%0d",
                             out_valid, out_idx, out_coeff, held_i, held_c);
                end
            end
            if (stall_run >= 3) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL in_ready_stall: got %b expected 0 after %0d stalled cycles", in_ready, stall_run);
                end
            end
            if (done === 1'b1) begin
                g_ndone++;
                finished = 1;
                break;
            end
            if (abort_at >= 0 && g_nout == abort_at) begin
                in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
                break;
            end
            in_valid = 1'b1;
            in_data  = gen_byte(pat, g_nbytes);
            if (stall && stall_left == 0 && $urandom_range(0, 3) == 0)
                stall_left = $urandom_range(1, 5);
            out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            if (poke && cyc == 50) begin
                start = 1'b1; d_sel = sel ^ 2'b01;
            end else begin
                start = 1'b0;
            end
            if (in_ready === 1'b1) g_nbytes++;
            holding = 0;
            if (out_valid === 1'b1) begin
                if (out_ready) begin
                    int exp_c = ref_coeff(pat, d, g_nout);
                    checks++;
                    if (out_idx !== 8'(g_nout) || out_coeff !== 16'(exp_c)) begin
                        errors++;
                        $display("FAIL coeff: got idx=%0d coeff=%0d expected idx=%0d coeff=%0d",
                                 out_idx, out_coeff, g_nout, exp_c);
                    end
                    if (g_nout < 2) g_first[g_nout] = out_coeff;
                    $display("coeff idx=%0d value=%0d", out_idx, out_coeff);
                    g_nout++;
                    stall_run = 0;
                end else begin
                    holding = 1; held_c = out_coeff; held_i = out_idx;
                    stall_run++;
                end
            end else begin
                stall_run = 0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (abort_at >= 0) return;
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL timeout: got no done in %0d cycles expected done", cyc);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (g_nout != 256 || g_nbytes != 32 * d) begin
            errors++;
            $display("FAIL totals: got %0d coeffs %0d bytes expected 256 coeffs %0d bytes", g_nout, g_nbytes, 32 * d);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_done: got done=%b busy=%b expected 0 0", done, busy);
        end
        $display("poly d=%0d coeffs=%0d bytes=%0d done_pulses=%0d", d, g_nout, g_nbytes, g_ndone);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_coeff !== 16'd0 ||
            out_idx !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b v=%b c=%0d i=%0d busy=%b done=%b expected all 0",
                     in_ready, out_valid, out_coeff, out_idx, busy, done);
        end
        rst = 1'b0;
        $display("reset checked");
    endtask

    task automatic test_d4();
        run_poly(2'b00, 1, 1'b0, -1, 1'b0);
        checks++;
        if (g_first[0] !== 16'd208 || g_first[1] !== 16'd416) begin
            errors++;
            $display("FAIL d4_head: got %0d %0d expected 208 416", g_first[0], g_first[1]);
        end
    endtask

    task automatic test_d10();
        run_poly(2'b10, 2, 1'b0, -1, 1'b0);
        checks++;
        if (g_first[0] !== 16'd3326 || g_ndone != 1) begin
            errors++;
            $display("FAIL d10_head: got %0d done=%0d expected 3326 done=1", g_first[0], g_ndone);
        end
    endtask

    task automatic test_d11_zero();
        run_poly(2'b11, 0, 1'b0, -1, 1'b0);
        checks++;
        if (g_first[0] !== 16'd0 || g_ndone != 1) begin
            errors++;
            $display("FAIL d11_zero: got %0d done=%0d expected 0 done=1", g_first[0], g_ndone);
        end
    endtask

    task automatic test_stall();
        run_poly(2'b10, 1, 1'b1, -1, 1'b0);
        run_poly(2'b00, 2, 1'b1, -1, 1'b0);
    endtask

    task automatic test_abort();
        run_poly(2'b10, 1, 1'b0, 100, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (g_ndone != 0 || out_valid !== 1'b0 || out_idx !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: got done_pulses=%0d v=%b idx=%0d busy=%b done=%b expected 0",
                     g_ndone, out_valid, out_idx, busy, done);
        end
        rst = 1'b0;
        $display("aborted at idx 100");
        run_poly(2'b01, 2, 1'b1, -1, 1'b0);
    endtask

    task automatic test_start_in_run();
        run_poly(2'b00, 1, 1'b1, -1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_d4();
        test_d10();
        test_d11_zero();
        test_stall();
        test_abort();
        test_start_in_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
